// File: rtl/pstats_cntr_bank_if.sv
// Host read port of the statistics counter bank: one-cycle strobe in,
// registered data and valid pulse out.
interface pstats_cntr_bank_if #(
  parameter int g_cnt_width  = 32,
  parameter int g_addr_width = 4
);
  logic                    rd_req_i;
  logic [g_addr_width-1:0] rd_addr_i;
  logic [g_cnt_width-1:0]  rd_data_o;
  logic                    rd_valid_o;

  modport master (output rd_req_i, output rd_addr_i, input rd_data_o, input rd_valid_o);
  modport slave  (input rd_req_i, input rd_addr_i, output rd_data_o, output rd_valid_o);
endinterface

// File: rtl/pstats_cntr_bank.sv
// Multi-port statistics counter bank: per-event pre-accumulators folded by a
// round-robin scanner into a wide counter array, read through a registered port.
module pstats_cntr_bank #(
  parameter int g_nports      = 2,
  parameter int g_cnt_pp      = 8,
  parameter int g_cnt_width   = 32,
  parameter int g_acc_width   = 5,
  parameter bit g_saturate    = 1'b1,
  parameter bit g_clr_on_read = 1'b0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [g_nports*g_cnt_pp-1:0]   events_i,
  input  logic                           clr_i,
  pstats_cntr_bank_if.slave              host,
  output logic [g_nports-1:0]            ovf_o,
  output logic [g_nports-1:0]            lost_o,
  output logic                           scan_wrap_o
);
  localparam int N  = g_nports * g_cnt_pp;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0]          LAST     = AW'(N - 1);
  localparam logic [AW-1:0]          SCAN_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [g_acc_width-1:0] ACC_ONE  = {{(g_acc_width-1){1'b0}}, 1'b1};
  localparam logic [g_acc_width-1:0] ACC_MAX  = '1;
  localparam logic [g_cnt_width-1:0] CNT_MAX  = '1;

  logic [g_cnt_width-1:0] mem [N];
  logic [g_acc_width-1:0] acc [N];
  logic [AW-1:0]          scan_idx;
  logic [AW-1:0]          s1_idx;
  logic                   s1_vld;
  logic [g_acc_width-1:0] snap;
  logic [g_cnt_width-1:0] cur;

  logic [g_cnt_width:0]   sum;
  logic                   sum_ovf;
  logic [g_cnt_width-1:0] wr_val;
  logic                   rd_in_range;
  logic                   rd_hit_wr;
  logic                   wr_hit_scan;
  logic                   cor_hit_scan;

  always_comb begin
    sum          = {1'b0, cur} + (g_cnt_width+1)'(snap);
    sum_ovf      = sum[g_cnt_width];
    wr_val       = (sum_ovf && g_saturate) ? CNT_MAX : sum[g_cnt_width-1:0];
    rd_in_range  = int'(host.rd_addr_i) < N;
    rd_hit_wr    = s1_vld && (s1_idx == host.rd_addr_i);
    wr_hit_scan  = s1_vld && (s1_idx == scan_idx);
    cor_hit_scan = g_clr_on_read && host.rd_req_i && rd_in_range &&
                   (host.rd_addr_i == scan_idx);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
        acc[i] <= '0;
      end
      scan_idx        <= '0;
      s1_idx          <= '0;
      s1_vld          <= 1'b0;
      snap            <= '0;
      cur             <= '0;
      ovf_o           <= '0;
      lost_o          <= '0;
      scan_wrap_o     <= 1'b0;
      host.rd_data_o  <= '0;
      host.rd_valid_o <= 1'b0;
    end else begin
      // The accumulator being scanned restarts from this cycle's event.
      for (int i = 0; i < N; i++) begin
        if (scan_idx == AW'(i)) begin
          acc[i] <= {{(g_acc_width-1){1'b0}}, events_i[i]};
        end else if (events_i[i]) begin
          if (acc[i] == ACC_MAX) lost_o[i / g_cnt_pp] <= 1'b1;
          else                   acc[i] <= acc[i] + ACC_ONE;
        end
      end

      snap   <= acc[scan_idx];
      s1_idx <= scan_idx;
      s1_vld <= 1'b1;
      if (cor_hit_scan)     cur <= '0;
      else if (wr_hit_scan) cur <= wr_val;
      else                  cur <= mem[scan_idx];
      scan_idx    <= (scan_idx == LAST) ? '0 : scan_idx + SCAN_ONE;
      scan_wrap_o <= (scan_idx == LAST);

      if (s1_vld) begin
        mem[s1_idx] <= wr_val;
        for (int i = 0; i < N; i++)
          if (sum_ovf && (s1_idx == AW'(i))) ovf_o[i / g_cnt_pp] <= 1'b1;
      end

      // Read is write-first; a clear-on-read overrides the same-cycle fold.
      host.rd_valid_o <= host.rd_req_i;
      if (host.rd_req_i) begin
        if (!rd_in_range)   host.rd_data_o <= '0;
        else if (rd_hit_wr) host.rd_data_o <= wr_val;
        else                host.rd_data_o <= mem[host.rd_addr_i];
        if (g_clr_on_read && rd_in_range) mem[host.rd_addr_i] <= '0;
      end
    end
  end
endmodule
